freq_meas: RTL and testbench
============================

Name: freq_meas

Overview:
Measures a periodic single-bit input, such as a divided clock or a periodic impulse train, in units of the system clock. It reports the period and the high time of each completed cycle of the input, and flags when successive measurements agree (locked). It also flags loss of the input (timeout). It sits on the receiving side of the divider and impulse generators and is used to check or recover their division ratio and duty cycle.

Parameters:
CNT_W, 8, width of the cycle counters and of the period/high_time outputs
TIMEOUT, 255, clk cycles without a rising edge before the input is declared lost; legal range 2 .. 2^CNT_W-1

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  synchronous reset, active-low; one clock, synchronous
sig_in  input  1  measured signal; may be asynchronous to clk
period  output  CNT_W  last measured period, in clk cycles
high_time  output  CNT_W  high cycles within the last measured period
meas_valid  output  1  one-cycle pulse; period/high_time updated this cycle
locked  output  1  last two measurements equal in both period and high_time
timeout  output  1  one-cycle pulse when the input is declared lost

Behaviour:
- Reset (reset_n=0 at a posedge): period=0, high_time=0, meas_valid=0, locked=0, timeout=0, all counters 0, synchronizer flops 0, state=SEARCH.
- Input path: 2-flop synchronizer (s1, s2) followed by a delay flop d.
  - rise = s2 & ~d; fall = ~s2 & d.
  - A rise is seen in the 3rd cycle after the posedge that first samples sig_in=1.
- cnt: counts clk cycles since the last rise.
  - On a rise cycle: cnt<=0.
  - Otherwise: cnt<=cnt+1, saturating at 2^CNT_W-1.
- hcnt: counts high cycles since the last rise.
  - On a rise cycle: hcnt<=1.
  - Else if s2=1: hcnt<=hcnt+1, saturating.
  - On a fall: hpend<=hcnt.
- State machine:
  - SEARCH: wait for a rise. Counters are not trusted. On rise: go to ARMED, no meas_valid.
  - ARMED: the first period is being counted. On rise: capture, go to TRACK.
  - TRACK: on each rise, capture.
  - ARMED/TRACK timeout: if cnt reaches TIMEOUT-1 with no rise, go to SEARCH next cycle, pulse timeout for 1 cycle, locked<=0. period and high_time keep their last values.
- Capture (registered; outputs change at the rise-cycle posedge):
  - period<=cnt+1, high_time<=hpend, meas_valid=1 for exactly that cycle.
  - Example: a divide-by-6 input gives period=6.
- Lock:
  - On a capture, locked<=1 if the new (period, high_time) equals the previous capture and the previous capture exists.
  - On a capture with a mismatch: locked<=0.
  - The first capture after SEARCH never sets locked.
- Boundary cases:
  - Rise and timeout in the same cycle: the rise wins; capture normally, no timeout.
  - Input stuck high: no fall and no rise, so timeout fires.
  - If no fall occurred since the last rise, hpend holds its stale value; the high_time reported is then undefined only in the stuck case, which always ends in timeout.
  - Periods longer than 2^CNT_W-1 are impossible because TIMEOUT ≤ 2^CNT_W-1.
  - Input pulses shorter than 1 clk may be missed; the minimum legal high and low time is 1 clk.
  - reset_n low mid-measurement: immediate return to reset values; the first rise after reset produces no meas_valid.
- Latency: sig_in rising edge to meas_valid is 3 clk (synchronizer plus detect).

Test Plan:
1. Divide-by-6, 50% duty input (3 high/3 low), toggling on clk edges → meas_valid every 6 cycles starting at the 2nd rise; period=6, high_time=3; locked=1 from the 2nd meas_valid onward.
2. 1-cycle impulse every 5 cycles → period=5, high_time=1; locked after the 2nd measurement; meas_valid spacing exactly 5.
3. Ratio change from 6 to 8 (4 high) mid-stream → first period=8 capture drops locked to 0; next capture (8,4) sets locked=1.
4. Input stops low after a rise, TIMEOUT=20 → timeout pulses once, 20 cycles after that rise's detect cycle; locked=0; period holds 6; the next rise gives no meas_valid, and the following one gives meas_valid.
5. reset_n=0 for 1 cycle mid-period while locked → all outputs 0 next cycle; the first rise afterwards gives no meas_valid; the second rise gives a correct period and locked=0.
6. Rise arriving in the same cycle cnt hits TIMEOUT-1 → capture with period=TIMEOUT, meas_valid=1, no timeout pulse, state stays TRACK.

Source files
------------

// File: rtl/freq_meas_if.sv
// Result bundle of the frequency meter.
//   sig_in     : measured single-bit signal (driven by the source)
//   period     : last measured period, in clk cycles
//   high_time  : high cycles within the last measured period
//   meas_valid : one-cycle pulse when period/high_time update
//   locked     : last two measurements equal in period and high_time
//   timeout    : one-cycle pulse when the input is declared lost
// master = the meter, slave = the source/consumer side.
interface freq_meas_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  modport master (
    input  sig_in,
    output period, high_time, meas_valid, locked, timeout
  );

  modport slave (
    output sig_in,
    input  period, high_time, meas_valid, locked, timeout
  );
endinterface

// File: rtl/freq_meas.sv
// Measures period and high time of a periodic single-bit input in clk cycles,
// flags when consecutive measurements agree (locked) and when the input is
// lost (timeout).
// Ports:
//   clk     : system clock, all logic on posedge
//   reset_n : synchronous active-low reset
//   bus     : freq_meas_if master (sig_in in, measurement results out)
module freq_meas #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  freq_meas_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    TRACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, d_q;
  logic [CNT_W-1:0] cnt_q, hcnt_q, hpend_q;
  logic [CNT_W-1:0] period_q, high_q;
  logic             mv_q, locked_q, tmo_q, have_prev_q;
  logic             rise, fall;
  logic             capture, tmo_d;
  logic [CNT_W-1:0] new_period;
  logic             match;

  // Edge detect on the synchronized input
  assign rise = s2_q & ~d_q;
  assign fall = ~s2_q & d_q;

  assign new_period = cnt_q + CNT_W'(1);
  assign match      = (new_period == period_q) && (hpend_q == high_q);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= SEARCH;
    else          state_q <= state_d;
  end

  // Next state; a rise takes priority over the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      SEARCH: begin
        if (rise) state_d = ARMED;
      end
      ARMED, TRACK: begin
        if (rise) begin
          capture = 1'b1;
          state_d = TRACK;
        end else if (cnt_q == TMO_CNT) begin
          tmo_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Synchronizer, cycle counters and registered results
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      d_q         <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      hpend_q     <= '0;
      period_q    <= '0;
      high_q      <= '0;
      mv_q        <= 1'b0;
      locked_q    <= 1'b0;
      tmo_q       <= 1'b0;
      have_prev_q <= 1'b0;
    end else begin
      s1_q <= bus.sig_in;
      s2_q <= s1_q;
      d_q  <= s2_q;

      if (rise)                  cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);

      if (rise)                           hcnt_q <= CNT_W'(1);
      else if (s2_q && hcnt_q != CNT_MAX) hcnt_q <= hcnt_q + CNT_W'(1);

      // hpend keeps the high count of the period currently being measured
      if (fall) hpend_q <= hcnt_q;

      mv_q  <= capture;
      tmo_q <= tmo_d;

      if (capture) begin
        period_q    <= new_period;
        high_q      <= hpend_q;
        locked_q    <= have_prev_q && match;
        have_prev_q <= 1'b1;
      end else if (tmo_d) begin
        // period/high_time hold; the next capture must not lock against them
        locked_q    <= 1'b0;
        have_prev_q <= 1'b0;
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = mv_q;
  assign bus.locked     = locked_q;
  assign bus.timeout    = tmo_q;

endmodule

// File: tb/tb_freq_meas.sv
// Directed bench for freq_meas with a scoreboard of expected measurements
// and timeout pulses, each tagged with the cycle it must appear in.
module tb_freq_meas;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMO   = 20;
  localparam int unsigned LAT   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  freq_meas_if #(.CNT_W(CNT_W)) bus ();

  freq_meas #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int unsigned p;
    int unsigned ht;
    logic        lk;
    int unsigned cyc;
  } meas_t;

  meas_t       mv_q[$];
  int unsigned to_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One input cycle starting with a rise; if mv, that rise must report (p, ht, lk)
  task automatic cyc_in(input int unsigned h, input int unsigned l, input bit mv,
                        input int unsigned p = 0, input int unsigned ht = 0,
                        input bit lk = 1'b0);
    meas_t e;
    if (mv) begin
      e.p   = p;
      e.ht  = ht;
      e.lk  = lk;
      e.cyc = cyc + LAT;
      mv_q.push_back(e);
    end
    bus.sig_in = 1'b1;
    repeat (h) @(negedge clk);
    bus.sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"},    32'(bus.period),    32'd0);
    chk({tag, "_high_time"}, 32'(bus.high_time), 32'd0);
    chk({tag, "_meas_valid"},32'(bus.meas_valid),32'd0);
    chk({tag, "_locked"},    32'(bus.locked),    32'd0);
    chk({tag, "_timeout"},   32'(bus.timeout),   32'd0);
  endtask

  // Scoreboard side: every pulse must match the oldest expectation
  always @(negedge clk) begin
    meas_t       e;
    int unsigned t;
    if (bus.meas_valid === 1'b1) begin
      chk("mv_expected", 32'(mv_q.size() != 0), 32'd1);
      if (mv_q.size() != 0) begin
        e = mv_q.pop_front();
        chk("period",     32'(bus.period),    e.p);
        chk("high_time",  32'(bus.high_time), e.ht);
        chk("locked",     32'(bus.locked),    32'(e.lk));
        chk("mv_cycle",   cyc,                e.cyc);
      end
    end
    if (bus.timeout === 1'b1) begin
      chk("timeout_expected", 32'(to_q.size() != 0), 32'd1);
      if (to_q.size() != 0) begin
        t = to_q.pop_front();
        chk("timeout_cycle", cyc, t);
      end
    end
  end

  initial begin
    bus.sig_in = 1'b0;
    reset_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Divide-by-6, 3 high / 3 low
    cyc_in(3, 3, 1'b0);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b0);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b1);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b1);

    // 1-cycle impulse every 5 cycles
    cyc_in(1, 4, 1'b1, 6, 3, 1'b1);
    cyc_in(1, 4, 1'b1, 5, 1, 1'b0);
    cyc_in(1, 4, 1'b1, 5, 1, 1'b1);
    cyc_in(1, 4, 1'b1, 5, 1, 1'b1);

    // Ratio change 6 -> 8
    cyc_in(3, 3, 1'b1, 5, 1, 1'b1);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b0);
    cyc_in(4, 4, 1'b1, 6, 3, 1'b1);
    cyc_in(4, 4, 1'b1, 8, 4, 1'b0);
    cyc_in(4, 4, 1'b1, 8, 4, 1'b1);

    // Input stops low after a rise: timeout TMO cycles after that capture
    cyc_in(3, 3, 1'b1, 8, 4, 1'b1);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b0);
    to_q.push_back(cyc + LAT + TMO);
    cyc_in(3, 30, 1'b1, 6, 3, 1'b1);
    chk("to_seen",        32'(to_q.size()),    32'd0);
    chk("to_locked",      32'(bus.locked),     32'd0);
    chk("to_period_hold", 32'(bus.period),     32'd6);
    chk("to_high_hold",   32'(bus.high_time),  32'd3);
    cyc_in(3, 3, 1'b0);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b0);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b1);

    // Reset mid-period while locked
    @(negedge clk);
    chk("pre_reset_locked", 32'(bus.locked), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    reset_n = 1'b1;
    cyc_in(3, 3, 1'b0);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b0);
    cyc_in(3, 3, 1'b1, 6, 3, 1'b1);

    // Period equal to TIMEOUT: rise wins over timeout
    cyc_in(5, 15, 1'b1, 6, 3, 1'b1);
    cyc_in(5, 15, 1'b1, TMO, 5, 1'b0);
    cyc_in(5, 15, 1'b1, TMO, 5, 1'b1);
    cyc_in(3, 3, 1'b1, TMO, 5, 1'b1);

    repeat (5) @(negedge clk);
    chk("mv_queue_drained", 32'(mv_q.size()), 32'd0);
    chk("to_queue_drained", 32'(to_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
